window_spike_player: RTL and testbench
======================================

WINDOW_SPIKE_PLAYER -- requirements
Module: window_spike_player

Interface
REQ-001 Parameter N_BINS, default 50, number of time bins per word window.
REQ-002 Parameter N_CH, default 16, number of spike channels per bin.
REQ-003 Parameter BIN_CYCLES, default 100, nominal clk cycles per bin.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 win_valid  input  1  word window offered.
REQ-007 win_ready  output  1  block accepts a window; high only in IDLE.
REQ-008 win_data  input  N_BINS*N_CH (800)  window; bin b at bits [b*16 +: 16], bit c = channel c.
REQ-009 abort  input  1  terminate playback.
REQ-010 spike_valid  output  1  spike event offered.
REQ-011 spike_ready  input  1  consumer accepts the spike event.
REQ-012 channel_id  output  4  channel of the offered spike.
REQ-013 bin_index  output  6  bin currently playing, 0..N_BINS-1.
REQ-014 frame_done  output  1  one-cycle pulse after the last bin ends.
REQ-015 overrun  output  1  sticky flag: some bin needed more than BIN_CYCLES cycles.

Function
REQ-016 States: IDLE, PLAY; any other encoding shall return to IDLE.
REQ-017 IDLE: win_ready=1; an edge with win_valid&win_ready shall latch win_data, load bin 0 mask, clear bin timer to 0, set bin_index=0, clear overrun, and enter PLAY.
REQ-018 PLAY: spike_valid = (mask != 0); channel_id = index of lowest set bit of mask (combinational from registered mask).
REQ-019 Handshake: channel_id shall stay stable while spike_valid=1 and spike_ready=0; a transfer (both high) shall clear that bit at the edge.
REQ-020 Channels within a bin shall be emitted in ascending order, one transfer per cycle maximum; zero bits cost no cycles.
REQ-021 Bin timer shall increment each PLAY cycle and saturate at BIN_CYCLES-1.
REQ-022 Bin ends at the edge where timer==BIN_CYCLES-1 and the mask is empty after that edge, whether emptied by a transfer on that edge or already empty.
REQ-023 If timer==BIN_CYCLES-1 with the mask non-empty, overrun shall be set; the bin shall end on the edge its last spike transfers, with no idle gap.
REQ-024 Bin end with bin_index<N_BINS-1 shall increment bin_index, load the next bin mask, and reset the timer to 0.
REQ-025 Bin end with bin_index==N_BINS-1 shall enter IDLE and assert frame_done for exactly the next cycle.
REQ-026 An all-zero window shall take exactly N_BINS*BIN_CYCLES PLAY cycles (5000 with defaults) and emit no spikes.
REQ-027 abort in PLAY shall enter IDLE at the next edge, dropping spike_valid even mid-handshake, with no frame_done pulse; abort in IDLE has no effect.
REQ-028 abort and win_valid both high in IDLE: the window shall be accepted.
REQ-029 win_valid in PLAY shall be ignored (win_ready=0); the window is not consumed.
REQ-030 overrun shall be held until the next window acceptance.

Reset
REQ-031 Reset shall force IDLE, mask=0, timer=0, bin_index=0, frame_done=0, overrun=0, spike_valid=0, channel_id=0, win_ready=1.
REQ-032 Reset asserted mid-frame shall abandon playback immediately, with no frame_done pulse.

Structure
REQ-033 Package cora_spike_pkg shall hold N_BINS, N_CH, BIN_CYCLES defaults, the derived widths (bin index 6, channel 4, timer 7), and the state enum.
REQ-034 Sub-module lsb_prio_enc (16-bit input, 4-bit index, any-set output) shall implement channel selection.

Verification
REQ-035 Window with bin 0 = 0x8001, rest zero, spike_ready=1 -> channel 0 in cycle 1 and channel 15 in cycle 2 after acceptance; frame_done 5000 cycles after acceptance; overrun=0.
REQ-036 All-zero window -> spike_valid never high; frame_done pulse exactly once, 5000 cycles after acceptance; win_ready=1 the cycle after.
REQ-037 Bin 3 = 0xFFFF, spike_ready=1 for 1 of every 8 cycles -> 16 spikes in order 0..15 with stable channel_id while stalled; overrun=1; bin 4 starts the edge after channel 15 transfers.
REQ-038 abort asserted with spike_valid=1 in bin 10 -> IDLE next cycle, spike_valid=0, win_ready=1, no frame_done pulse.
REQ-039 rst_n pulsed low mid-bin 20 -> all outputs at reset values asynchronously; a new window is accepted normally afterwards.
REQ-040 win_valid held high during PLAY -> no second acceptance until frame_done; the next window is accepted on the first IDLE cycle.

Source files
------------

// File: rtl/cora_spike_pkg.sv
// cora_spike_pkg: default sizes, derived field widths and FSM state encoding
// shared by the window spike player and its channel encoder.
package cora_spike_pkg;
    localparam int N_BINS_DEF     = 50;
    localparam int N_CH_DEF       = 16;
    localparam int BIN_CYCLES_DEF = 100;
    localparam int BIN_W          = 6;
    localparam int CH_W           = 4;
    localparam int TMR_W          = 7;
    typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;
endpackage

// File: rtl/lsb_prio_enc.sv
// lsb_prio_enc: index of the lowest set bit of a channel mask, plus any-set flag.
module lsb_prio_enc
    import cora_spike_pkg::*;
(
    input  logic [N_CH_DEF-1:0] req,
    output logic [CH_W-1:0]     idx,
    output logic                any
);
    always_comb begin
        idx = '0;
        for (int i = N_CH_DEF - 1; i >= 0; i--) idx = req[i] ? CH_W'(i) : idx;
    end
    assign any = |req;
endmodule

// File: rtl/window_spike_player.sv
// window_spike_player: replays a latched window of per-bin spike masks as a
// valid/ready stream of channel ids, one bin per BIN_CYCLES clock cycles.
module window_spike_player
    import cora_spike_pkg::*;
#(
    parameter int N_BINS     = N_BINS_DEF,
    parameter int N_CH       = N_CH_DEF,
    parameter int BIN_CYCLES = BIN_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   win_valid,
    output logic                   win_ready,
    input  logic [N_BINS*N_CH-1:0] win_data,
    input  logic                   abort,
    output logic                   spike_valid,
    input  logic                   spike_ready,
    output logic [CH_W-1:0]        channel_id,
    output logic [BIN_W-1:0]       bin_index,
    output logic                   frame_done,
    output logic                   overrun
);
    state_t                         state, state_nx;
    logic [N_BINS-1:0][N_CH-1:0]    win, win_nx;
    logic [N_CH-1:0]                mask, mask_nx, mask_left;
    logic [TMR_W-1:0]               timer, timer_nx;
    logic [BIN_W-1:0]               bin_nx;
    logic                           done_nx, ovr_nx, any, tmax, last_bin;

    lsb_prio_enc u_enc (.req(mask), .idx(channel_id), .any(any));

    assign win_ready   = state == IDLE;
    assign spike_valid = state == PLAY && any;
    assign mask_left   = spike_valid && spike_ready ? mask & ~(N_CH'(1) << channel_id) : mask;
    assign tmax        = timer == TMR_W'(BIN_CYCLES - 1);
    assign last_bin    = bin_index == BIN_W'(N_BINS - 1);

    always_comb begin
        state_nx = state;
        win_nx   = win;
        mask_nx  = mask;
        timer_nx = timer;
        bin_nx   = bin_index;
        done_nx  = 1'b0;
        ovr_nx   = overrun;
        if (state == IDLE) begin
            if (win_valid) begin
                state_nx = PLAY;
                win_nx   = win_data;
                mask_nx  = win_data[N_CH-1:0];
                timer_nx = '0;
                bin_nx   = '0;
                ovr_nx   = 1'b0;
            end
        end else if (state == PLAY) begin
            if (abort) begin
                state_nx = IDLE;
                mask_nx  = '0;
            end else begin
                mask_nx  = mask_left;
                timer_nx = tmax ? timer : timer + 1'b1;
                // a bin still holding spikes at its final cycle stretches until drained
                ovr_nx   = overrun || (tmax && mask_left != '0);
                if (tmax && mask_left == '0) begin
                    timer_nx = '0;
                    state_nx = last_bin ? IDLE : PLAY;
                    done_nx  = last_bin;
                    bin_nx   = last_bin ? bin_index : bin_index + 1'b1;
                    mask_nx  = last_bin ? '0 : win[bin_index + 1'b1];
                end
            end
        end else begin
            state_nx = IDLE;
            mask_nx  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            win        <= '0;
            mask       <= '0;
            timer      <= '0;
            bin_index  <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nx;
            win        <= win_nx;
            mask       <= mask_nx;
            timer      <= timer_nx;
            bin_index  <= bin_nx;
            frame_done <= done_nx;
            overrun    <= ovr_nx;
        end
    end
endmodule

// File: tb/tb_window_spike_player.sv
// tb_window_spike_player: directed scenarios for window_spike_player with
// hand-computed cycle counts and channel sequences.
module tb_window_spike_player;
    import cora_spike_pkg::*;
    localparam int W = N_BINS_DEF * N_CH_DEF;

    logic         clk = 1'b0, rst_n = 1'b0, win_valid = 1'b0, abort = 1'b0, spike_ready = 1'b0;
    logic [W-1:0] win_data = '0;
    logic         win_ready, spike_valid, frame_done, overrun;
    logic [3:0]   channel_id;
    logic [5:0]   bin_index;
    int           tests = 0, fails = 0;

    always #5 clk = ~clk;

    window_spike_player dut (
        .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .win_ready(win_ready),
        .win_data(win_data), .abort(abort), .spike_valid(spike_valid),
        .spike_ready(spike_ready), .channel_id(channel_id), .bin_index(bin_index),
        .frame_done(frame_done), .overrun(overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] w);
        win_data  = w;
        win_valid = 1'b1;
        step();
        win_valid = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        tests++; if (win_ready !== 1'b1) begin fails++; $display("FAIL reset_win_ready got %b want 1", win_ready); end
        tests++; if (spike_valid !== 1'b0) begin fails++; $display("FAIL reset_spike_valid got %b want 0", spike_valid); end
        tests++; if (channel_id !== 4'd0) begin fails++; $display("FAIL reset_channel_id got %0d want 0", channel_id); end
        tests++; if (bin_index !== 6'd0) begin fails++; $display("FAIL reset_bin_index got %0d want 0", bin_index); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_two_spikes();
        logic [W-1:0] w;
        int k;
        w = '0;
        w[15:0] = 16'h8001;
        spike_ready = 1'b1;
        accept(w);
        tests++; if (spike_valid !== 1'b1 || channel_id !== 4'd0) begin fails++; $display("FAIL first_spike got v=%b ch=%0d want v=1 ch=0", spike_valid, channel_id); end
        tests++; if (win_ready !== 1'b0) begin fails++; $display("FAIL play_win_ready got %b want 0", win_ready); end
        step();
        tests++; if (spike_valid !== 1'b1 || channel_id !== 4'd15) begin fails++; $display("FAIL second_spike got v=%b ch=%0d want v=1 ch=15", spike_valid, channel_id); end
        step();
        tests++; if (spike_valid !== 1'b0) begin fails++; $display("FAIL bin0_drained got %b want 0", spike_valid); end
        k = 2;
        while (frame_done !== 1'b1 && k < 6000) begin step(); k++; end
        tests++; if (k != 5000) begin fails++; $display("FAIL two_spikes_frame_len got %0d want 5000", k); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL two_spikes_overrun got %b want 0", overrun); end
        spike_ready = 1'b0;
        step();
    endtask

    task automatic test_all_zero();
        int k;
        logic seen;
        accept('0);
        k = 0;
        seen = spike_valid;
        while (frame_done !== 1'b1 && k < 6000) begin step(); k++; seen |= spike_valid; end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL zero_no_spikes got %b want 0", seen); end
        tests++; if (k != 5000) begin fails++; $display("FAIL zero_frame_len got %0d want 5000", k); end
        tests++; if (win_ready !== 1'b1) begin fails++; $display("FAIL zero_done_ready got %b want 1", win_ready); end
        step();
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL zero_done_pulse got %b want 0", frame_done); end
        tests++; if (win_ready !== 1'b1) begin fails++; $display("FAIL zero_after_ready got %b want 1", win_ready); end
    endtask

    task automatic test_overrun();
        logic [W-1:0] w;
        int k, ph, expc;
        logic ok;
        w = '0;
        w[3*16 +: 16] = 16'hFFFF;
        accept(w);
        k = 0;
        while (bin_index !== 6'd3 && k < 1000) begin step(); k++; end
        tests++; if (k != 300) begin fails++; $display("FAIL bin3_start got %0d want 300", k); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_early got %b want 0", overrun); end
        ph = 0; expc = 0; ok = 1'b1;
        while (bin_index === 6'd3 && ph < 200) begin
            if (spike_valid !== 1'b1 || channel_id !== 4'(expc)) ok = 1'b0;
            spike_ready = (ph % 8 == 7);
            step();
            if (spike_ready) expc++;
            ph++;
        end
        spike_ready = 1'b0;
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL stall_order got %b want 1", ok); end
        tests++; if (expc != 16) begin fails++; $display("FAIL stall_count got %0d want 16", expc); end
        tests++; if (ph != 128 || bin_index !== 6'd4) begin fails++; $display("FAIL bin4_start got ph=%0d bin=%0d want ph=128 bin=4", ph, bin_index); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set got %b want 1", overrun); end
        k = 428;
        while (frame_done !== 1'b1 && k < 7000) begin step(); k++; end
        tests++; if (k != 5028) begin fails++; $display("FAIL overrun_frame_len got %0d want 5028", k); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_held got %b want 1", overrun); end
    endtask

    task automatic test_abort();
        logic [W-1:0] w;
        int k;
        logic seen;
        w = '0;
        w[10*16 +: 16] = 16'h0F00;
        accept(w);
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_cleared got %b want 0", overrun); end
        k = 0;
        while (bin_index !== 6'd10 && k < 2000) begin step(); k++; end
        tests++; if (k != 1000 || spike_valid !== 1'b1 || channel_id !== 4'd8) begin fails++; $display("FAIL bin10_spike got k=%0d v=%b ch=%0d want k=1000 v=1 ch=8", k, spike_valid, channel_id); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++; if (spike_valid !== 1'b0 || win_ready !== 1'b1) begin fails++; $display("FAIL abort_idle got v=%b rdy=%b want v=0 rdy=1", spike_valid, win_ready); end
        seen = frame_done;
        for (int i = 0; i < 3; i++) begin step(); seen |= frame_done; end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_done got %b want 0", seen); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w;
        int k;
        w = '0;
        w[20*16 +: 16] = 16'h0010;
        accept(w);
        k = 0;
        while (bin_index !== 6'd20 && k < 3000) begin step(); k++; end
        step(); step(); step();
        tests++; if (spike_valid !== 1'b1 || channel_id !== 4'd4) begin fails++; $display("FAIL bin20_spike got v=%b ch=%0d want v=1 ch=4", spike_valid, channel_id); end
        rst_n = 1'b0;
        #2;
        tests++; if (spike_valid !== 1'b0 || win_ready !== 1'b1 || channel_id !== 4'd0 || bin_index !== 6'd0 || frame_done !== 1'b0 || overrun !== 1'b0)
            begin fails++; $display("FAIL async_reset got v=%b rdy=%b ch=%0d bin=%0d fd=%b ov=%b want 0 1 0 0 0 0", spike_valid, win_ready, channel_id, bin_index, frame_done, overrun); end
        step();
        rst_n = 1'b1;
        step();
        w = '0;
        w[15:0] = 16'h0004;
        win_data = w;
        win_valid = 1'b1;
        abort = 1'b1;
        step();
        win_valid = 1'b0;
        abort = 1'b0;
        tests++; if (win_ready !== 1'b0 || spike_valid !== 1'b1 || channel_id !== 4'd2) begin fails++; $display("FAIL accept_with_abort got rdy=%b v=%b ch=%0d want 0 1 2", win_ready, spike_valid, channel_id); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++; if (win_ready !== 1'b1) begin fails++; $display("FAIL post_reset_abort got %b want 1", win_ready); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w;
        int k;
        logic rdy;
        win_data  = '0;
        win_valid = 1'b1;
        step();
        k = 0;
        rdy = 1'b0;
        while (frame_done !== 1'b1 && k < 6000) begin rdy |= win_ready; step(); k++; end
        tests++; if (rdy !== 1'b0 || k != 5000) begin fails++; $display("FAIL held_valid got rdy=%b k=%0d want rdy=0 k=5000", rdy, k); end
        w = '0;
        w[15:0] = 16'h0100;
        win_data = w;
        step();
        win_valid = 1'b0;
        tests++; if (win_ready !== 1'b0 || spike_valid !== 1'b1 || channel_id !== 4'd8 || bin_index !== 6'd0)
            begin fails++; $display("FAIL next_accept got rdy=%b v=%b ch=%0d bin=%0d want 0 1 8 0", win_ready, spike_valid, channel_id, bin_index); end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_two_spikes();
        test_all_zero();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
